// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Purpose: CPU-wide basic types shared across the datapath.
//   word_t : 32-bit machine word / program counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// dp_types_pkg
// Purpose: datapath types shared between the branch predictor and the
// branch resolution unit.
//   BP_IDX_W    : predictor table index width.
//   bp_update_t : one predictor training entry {idx, tag, taken, target}.
package dp_types_pkg;
  import cpu_types_pkg::*;

  localparam int BP_IDX_W = 4;
  localparam int BP_TAG_W = 30 - BP_IDX_W;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic [BP_TAG_W-1:0] tag;
    logic                taken;
    word_t               target;
  } bp_update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo
// Purpose: small FIFO of predictor training entries between the branch
// resolution unit and the predictor table.
// Ports:
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   push, din : enqueue request and entry
//   pop       : dequeue request (ignored when empty)
//   dout      : head entry, combinational from storage
//   full      : QDEPTH entries held
//   empty     : no entries held
//   drop      : one-cycle pulse, a push was discarded because the queue was
//               full and nothing was popped in the same cycle
// QDEPTH must be a power of two >= 2 so the pointers wrap by overflow.
module bp_update_fifo
  import dp_types_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       push,
  input  bp_update_t din,
  input  logic       pop,
  output bp_update_t dout,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  bp_update_t      mem [QDEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // A push into a full queue is still taken when the head leaves the same
  // cycle; only a push into a full queue with no pop is lost.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= push & full & ~do_pop;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Purpose: end-of-EX branch resolution. Compares the actual outcome with the
// prediction carried down the pipe, raises a registered one-cycle flush with
// the corrected PC on a mispredict, and queues a training entry for every
// resolved branch toward the predictor over a valid/ready handshake.
// Ports:
//   CLK, nRST            : clock (rising edge), asynchronous active-low reset
//   res_valid, stall     : resolution present / pipeline stalled
//   res_pc, res_pc4      : branch PC and PC+4
//   res_taken,res_target : actual direction and target
//   pred_taken,pred_target : prediction carried with the instruction
//   flush, npc_fix       : mispredict pulse and corrected next PC
//   upd_valid/upd_ready  : training handshake
//   upd_idx/tag/taken/target : head training entry
//   upd_drop             : pulse, a training entry was lost (queue full)
// Optional (macro BRANCH_STATS_EN): stat_branches, stat_mispred counters.
//
// Handshake: an entry transfers on a rising edge where upd_valid and
// upd_ready are both high; while upd_valid is high and upd_ready low the
// upd_* fields hold steady. Draining is independent of stall.
// IDX_W must equal BP_IDX_W so the index fits the training entry.
module branch_resolve_unit
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int IDX_W  = BP_IDX_W,
  parameter int QDEPTH = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                res_valid,
  input  logic                stall,
  input  logic [31:0]         res_pc,
  input  logic [31:0]         res_pc4,
  input  logic                res_taken,
  input  logic [31:0]         res_target,
  input  logic                pred_taken,
  input  logic [31:0]         pred_target,
  output logic                flush,
  output logic [31:0]         npc_fix,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [IDX_W-1:0]    upd_idx,
  output logic [29-IDX_W:0]   upd_tag,
  output logic                upd_taken,
  output logic [31:0]         upd_target,
  output logic                upd_drop
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
`endif
);

  logic       acc;
  logic       mis;
  logic       fifo_full;
  logic       fifo_empty;
  bp_update_t new_entry;
  bp_update_t head_entry;
  word_t      fix_pc;
  logic       unused_pc_bits;

  // A resolution arriving while flush is high is on the wrong path.
  assign acc = res_valid & ~stall & ~flush;

  // Not-taken on both sides agrees regardless of target.
  assign mis = (res_taken != pred_taken) |
               (res_taken & pred_taken & (res_target != pred_target));

  assign fix_pc = res_taken ? res_target : res_pc4;

  assign unused_pc_bits = ^res_pc[1:0];

  always_comb begin
    new_entry        = '0;
    new_entry.idx    = res_pc[IDX_W+1:2];
    new_entry.tag    = res_pc[31:IDX_W+2];
    new_entry.taken  = res_taken;
    new_entry.target = res_target;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush   <= 1'b0;
      npc_fix <= '0;
    end else begin
      flush <= acc & mis;
      if (acc & mis) npc_fix <= fix_pc;
    end
  end

  bp_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (acc),
    .din   (new_entry),
    .pop   (upd_valid & upd_ready),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (upd_drop)
  );

  assign upd_valid  = ~fifo_empty;
  assign upd_idx    = head_entry.idx;
  assign upd_tag    = head_entry.tag;
  assign upd_taken  = head_entry.taken;
  assign upd_target = head_entry.target;

  logic unused_full;
  assign unused_full = fifo_full;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (acc)       stat_branches <= stat_branches + 32'd1;
      if (acc & mis) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side counterpart to the fetch-side predictor.
- Sits at the end of EX and compares the actual branch outcome with the prediction carried down the pipeline.
- On a mismatch it raises a one-cycle flush with the corrected PC.
- For every resolved branch it queues a training write toward the predictor table over a valid/ready handshake.

Parameters:
- IDX_W, 4: predictor table index width; index = res_pc[IDX_W+1:2].
- QDEPTH, 2: depth of the training-update FIFO; power of two, ≥2.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- res_valid  in  1  branch/jump resolved in EX this cycle.
- stall  in  1  pipeline stall; resolution not accepted while high.
- res_pc  in  32  PC of resolving branch (word_t).
- res_pc4  in  32  res_pc + 4.
- res_taken  in  1  actual direction.
- res_target  in  32  computed target.
- pred_taken  in  1  predicted direction (phit carried down pipeline).
- pred_target  in  32  predicted target.
- flush  out  1  mispredict flush pulse.
- npc_fix  out  32  corrected next PC, valid while flush = 1.
- upd_valid  out  1  training entry available.
- upd_ready  in  1  predictor accepts entry.
- upd_idx  out  IDX_W  table index.
- upd_tag  out  30-IDX_W  res_pc[31:IDX_W+2].
- upd_taken  out  1  actual direction.
- upd_target  out  32  actual target.
- upd_drop  out  1  pulse: update lost, queue full.

Behaviour:
- Reset (async, nRST=0): flush=0, npc_fix=0, upd_valid=0, upd_drop=0, FIFO empty, pointers and count cleared. Reset mid-transfer discards all queued updates.
- Accept condition: acc = res_valid & ~stall & ~flush.
  - res_valid in the same cycle flush is high is a wrong-path branch: ignored (no flush, no enqueue).
- Mispredict: mis = (res_taken ≠ pred_taken) | (res_taken & pred_taken & (res_target ≠ pred_target)).
- Latency: flush registered; asserted exactly one cycle after an accepted mispredicting resolution, for one cycle.
  - npc_fix = res_taken ? res_target : res_pc4, registered alongside flush.
  - flush=0 → npc_fix holds its last value.
- Training: every accepted resolution (correct or not) pushes {idx, tag, taken, target}.
- FIFO:
  - Head drives upd_* combinationally; upd_valid = ~empty.
  - Pop on upd_valid & upd_ready.
  - Push and pop in the same cycle are both allowed when full; count unchanged.
  - Push when full with no pop: entry discarded, upd_drop = 1 next cycle for one cycle; queue contents unchanged.
  - Pointers wrap modulo QDEPTH; count width clog2(QDEPTH)+1.
- upd_* must stay stable while upd_valid & ~upd_ready.
- stall does not block draining; pops continue during stall.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches[31:0] and stat_mispred[31:0], both reset to 0.
  - stat_branches increments on each acc; stat_mispred increments on acc & mis.
  - Both counters wrap at 2^32.
- Not defined: ports absent, no counters.

Decomposition:
- dp_types_pkg gains:
  - bp_update_t packed struct {idx, tag, taken, target}.
  - constant BP_IDX_W = 4.
- word_t comes from cpu_types_pkg.
- One sub-module: bp_update_fifo (parameterised on QDEPTH, holds bp_update_t, push/pop/full/empty, wrap logic).
- The top holds compare, flush registers, and optional stats.

Test Plan:
- Reset mid-queue: push 2 updates, upd_ready=0, pulse nRST low → flush=0, upd_valid=0 immediately; after release, queue empty.
- Correct prediction: res_pc=0x100, taken=pred_taken=1, targets 0x200 → no flush; next cycle upd_valid=1, upd_idx=0x0, upd_tag=0x100>>6, upd_target=0x200.
- Direction mispredict: pred_taken=1, res_taken=0, res_pc4=0x104 → flush=1 one cycle later for exactly one cycle, npc_fix=0x104; a res_valid in that flush cycle → no enqueue, no second flush.
- Target mispredict: both taken, pred_target=0x300, res_target=0x340 → flush=1, npc_fix=0x340.
- Backpressure: upd_ready=0, 3 accepted resolutions with QDEPTH=2 → first 2 queued, upd_drop=1 once; then upd_ready=1 → entries drain in order.
- Stall and stats: stall=1 with res_valid=1 → no flush, no enqueue; with BRANCH_STATS_EN, 5 resolutions including 2 mispredicts → stat_branches=5, stat_mispred=2.
